alu_mc: RTL and testbench
=========================

// Module: alu_mc
// PURPOSE
//  Parametrised, multi-cycle successor to the single-cycle core ALU. Executes the RV32I
//  ALU/compare ops with a registered result (1-cycle latency). Optionally adds the RV M
//  extension through an iterative shift-add multiplier and restoring divider.
//  Sits in EX between operand muxes and the EX/MEM register; stalls the pipe via in_ready.
// PARAMETERS
//  XLEN     32            datapath width, power of two >= 8
//  SHAMT_W  $clog2(XLEN)  shift-amount width; derived, not overridden
// PORTS
//  clk        in   1     single clock, rising edge
//  rst_n      in   1     asynchronous, active-low reset
//  flush      in   1     sync abort of in-flight op and pending result (branch/trap)
//  in_valid   in   1     op1/op2/sel/is_signed valid
//  in_ready   out  1     block can accept an op this cycle
//  op1        in   XLEN  operand A
//  op2        in   XLEN  operand B; shifts use op2[SHAMT_W-1:0]
//  sel        in   5     opcode, see BEHAVIOUR
//  is_signed  in   1     N-flag compare mode for SUB
//  out_valid  out  1     result/Z/N/err valid
//  out_ready  in   1     consumer takes result
//  result     out  XLEN  registered result
//  Z          out  1     result == 0
//  N          out  1     SUB: op1<op2 (signed if is_signed, else unsigned); else result[XLEN-1]
//  err        out  1     sel was undefined (or M op with ALU_MDU_EN undefined)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, out_valid=0, result=0, Z=0, N=0, err=0; in_ready=1 after release.
//  - sel: 0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLL,6 SRL,7 SRA,8 SLT,9 SLTU, 10 MUL,11 MULH,
//    12 MULHSU,13 MULHU,14 DIV,15 DIVU,16 REM,17 REMU; others undefined -> result 0, Z=1, N=0, err=1.
//  - All arithmetic modulo 2^XLEN; SLT/SLTU yield 0 or 1.
//  - Accept = in_valid & in_ready. in_ready = (state==IDLE) & (~out_valid | out_ready) & ~flush.
//  - States: IDLE, MUL, DIV. Ops 0-9/undefined: accept in IDLE -> result regs loaded same edge,
//    out_valid=1 next cycle (latency 1). Back-to-back ops at full rate while out_ready=1.
//  - Ops 10-13: IDLE->MUL; operands latched as magnitudes, sign of product recorded; XLEN
//    iterations of 2*XLEN-bit shift-add; sign fix and output load on the last iteration;
//    ->IDLE. out_valid asserts exactly XLEN+1 cycles after accept.
//  - Ops 14-17: IDLE->DIV; restoring division on magnitudes, XLEN iterations, sign fix;
//    out_valid at XLEN+1 cycles after accept.
//  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = op1. Signed overflow
//    (op1=MIN, op2=-1): DIV = MIN, REM = 0. Both still take XLEN+1 cycles.
//  - Output hold: out_valid=1 & out_ready=0 keeps result/Z/N/err stable; in_ready=0.
//    out_valid drops the cycle after out_ready=1 unless a new op completes that edge.
//  - Z, N, err computed from the final result and registered with it.
//  - flush: sync, highest priority over accept/complete: state->IDLE, out_valid->0,
//    iteration counter cleared; no result for aborted op. in_ready=0 during flush cycle.
//  - Reset mid-iteration: immediate abort, all outputs to reset values.
// CONFIGURATION
//  ALU_MDU_EN defined: MUL/DIV states, iteration counter and 2*XLEN datapath present;
//  sel 10-17 as above.
//  ALU_MDU_EN undefined: only IDLE; sel 10-17 treated as undefined (1 cycle, result 0,
//  Z=1, err=1); no multiplier/divider logic synthesised.
// TESTING
//  1. ADD op1=5, op2=7, out_ready=1 -> next cycle out_valid=1, result=12, Z=0, N=0.
//  2. SUB op1=0xFFFFFFFF op2=1: is_signed=1 -> N=1; is_signed=0 -> N=0; SUB 9-9 -> Z=1.
//  3. [MDU] MULHU 0x00010000*0x00010000 -> out_valid at cycle 33, result=1; MUL same -> 0, Z=1;
//     MULH 0xFFFFFFFF*0xFFFFFFFF -> 0; in_ready=0 for cycles 1..33.
//  4. [MDU] DIV 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7; DIV 0x80000000/-1 -> 0x80000000; REM -> 0;
//     DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF.
//  5. Backpressure: XOR 0xF0^0xFF with out_ready=0 for 5 cycles -> result 0x0F held, in_ready=0;
//     out_ready=1 -> out_valid drops next cycle, next op accepted.
//  6. flush at cycle 10 of DIVU, then rst_n pulse during MUL -> no out_valid, state IDLE,
//     in_ready=1 next cycle; sel=31 -> err=1, result=0, Z=1.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: RV32I ALU/compare unit with a registered result and valid/ready handshake.
// Defining ALU_MDU_EN adds the RV M extension (iterative shift-add multiply, restoring divide).
module alu_mc #(
    parameter  int XLEN    = 32,
    localparam int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [4:0]      sel,
    input  logic            is_signed,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            Z,
    output logic            N,
    output logic            err
);

    logic               w_accept;
    logic               w_fin_vld;
    logic [XLEN-1:0]    w_fin_res;
    logic               w_fin_n;
    logic               w_fin_err;
    logic [XLEN-1:0]    w_alu_res;
    logic               w_alu_n;
    logic               w_alu_err;
    logic [SHAMT_W-1:0] w_shamt;
    logic               r_out_valid;
    logic [XLEN-1:0]    r_result;
    logic               r_z;
    logic               r_n;
    logic               r_err;

    assign w_shamt  = op2[SHAMT_W-1:0];
    assign w_accept = in_valid & in_ready;

    always_comb begin
        w_alu_res = '0;
        w_alu_err = 1'b0;
        w_alu_n   = 1'b0;
        case (sel)
            5'd0:    w_alu_res = op1 + op2;
            5'd1:    w_alu_res = op1 - op2;
            5'd2:    w_alu_res = op1 & op2;
            5'd3:    w_alu_res = op1 | op2;
            5'd4:    w_alu_res = op1 ^ op2;
            5'd5:    w_alu_res = op1 << w_shamt;
            5'd6:    w_alu_res = op1 >> w_shamt;
            5'd7:    w_alu_res = $unsigned($signed(op1) >>> w_shamt);
            5'd8:    w_alu_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
            5'd9:    w_alu_res = {{(XLEN-1){1'b0}}, op1 < op2};
            default: w_alu_err = 1'b1;
        endcase
        // SUB reports operand ordering, not the sign of the wrapped difference
        if (sel == 5'd1)
            w_alu_n = is_signed ? ($signed(op1) < $signed(op2)) : (op1 < op2);
        else
            w_alu_n = w_alu_res[XLEN-1];
    end

`ifdef ALU_MDU_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t             r_state;
    logic [2*XLEN-1:0]  r_acc;     // MUL: {partial product, multiplier}; DIV: {remainder, dividend->quotient}
    logic [XLEN-1:0]    r_opb;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_neg;
    logic               r_hi;
    logic               w_is_mul;
    logic               w_is_div;
    logic               w_sgn1;
    logic               w_sgn2;
    logic               w_neg1;
    logic               w_neg2;
    logic               w_last;
    logic [XLEN-1:0]    w_mag1;
    logic [XLEN-1:0]    w_mag2;
    logic [XLEN-1:0]    w_div_val;
    logic [XLEN-1:0]    w_mdu_res;
    logic [XLEN:0]      w_sum;
    logic [XLEN:0]      w_rem_sh;
    logic [XLEN:0]      w_diff;
    logic [2*XLEN-1:0]  w_acc_nxt;
    logic [2*XLEN-1:0]  w_prod;

    assign w_is_mul = (sel >= 5'd10) && (sel <= 5'd13);
    assign w_is_div = (sel >= 5'd14) && (sel <= 5'd17);
    assign w_sgn1   = (sel == 5'd11) || (sel == 5'd12) || (sel == 5'd14) || (sel == 5'd16);
    assign w_sgn2   = (sel == 5'd11) || (sel == 5'd14) || (sel == 5'd16);
    assign w_neg1   = w_sgn1 & op1[XLEN-1];
    assign w_neg2   = w_sgn2 & op2[XLEN-1];
    assign w_mag1   = w_neg1 ? -op1 : op1;
    assign w_mag2   = w_neg2 ? -op2 : op2;
    assign w_last   = (r_cnt == SHAMT_W'(XLEN-1));

    assign w_sum    = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opb};
    assign w_rem_sh = r_acc[2*XLEN-1:XLEN-1];
    assign w_diff   = w_rem_sh - {1'b0, r_opb};

    always_comb begin
        if (r_state == S_MUL)
            w_acc_nxt = r_acc[0] ? {w_sum, r_acc[XLEN-1:1]} : {1'b0, r_acc[2*XLEN-1:1]};
        else if (w_diff[XLEN])
            w_acc_nxt = {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
        else
            w_acc_nxt = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    end

    assign w_prod    = r_neg ? -w_acc_nxt : w_acc_nxt;
    assign w_div_val = r_hi ? w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[XLEN-1:0];
    assign w_mdu_res = (r_state == S_MUL) ? (r_hi ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0])
                                          : (r_neg ? -w_div_val : w_div_val);

    // Divide-by-zero never negates the quotient so DIV x/0 stays all ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_opb   <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_hi    <= 1'b0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && (w_is_mul || w_is_div)) begin
                        r_cnt <= '0;
                        if (w_is_mul) begin
                            r_state <= S_MUL;
                            r_acc   <= {{XLEN{1'b0}}, w_mag2};
                            r_opb   <= w_mag1;
                            r_neg   <= w_neg1 ^ w_neg2;
                            r_hi    <= (sel != 5'd10);
                        end else begin
                            r_state <= S_DIV;
                            r_acc   <= {{XLEN{1'b0}}, w_mag1};
                            r_opb   <= w_mag2;
                            r_neg   <= (sel == 5'd16) ? w_neg1 : ((w_neg1 ^ w_neg2) & (op2 != '0));
                            r_hi    <= (sel >= 5'd16);
                        end
                    end
                end
                default: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + SHAMT_W'(1);
                    if (w_last) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end
                end
            endcase
        end
    end

    assign in_ready = (r_state == S_IDLE) & (~r_out_valid | out_ready) & ~flush;

    always_comb begin
        w_fin_vld = w_accept & ~(w_is_mul | w_is_div);
        w_fin_res = w_alu_res;
        w_fin_n   = w_alu_n;
        w_fin_err = w_alu_err;
        if (r_state != S_IDLE) begin
            w_fin_vld = w_last;
            w_fin_res = w_mdu_res;
            w_fin_n   = w_mdu_res[XLEN-1];
            w_fin_err = 1'b0;
        end
    end
`else
    assign in_ready  = (~r_out_valid | out_ready) & ~flush;
    assign w_fin_vld = w_accept;
    assign w_fin_res = w_alu_res;
    assign w_fin_n   = w_alu_n;
    assign w_fin_err = w_alu_err;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_z         <= 1'b0;
            r_n         <= 1'b0;
            r_err       <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_fin_vld) begin
            r_out_valid <= 1'b1;
            r_result    <= w_fin_res;
            r_z         <= (w_fin_res == '0);
            r_n         <= w_fin_n;
            r_err       <= w_fin_err;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign Z         = r_z;
    assign N         = r_n;
    assign err       = r_err;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed vector table, handshake/flush/reset sequences, random ops vs a model.
// Compile with +define+ALU_MDU_EN to exercise the multiply/divide unit.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush, in_valid, in_ready, is_signed, out_valid, out_ready, Z, N, err;
    logic [31:0] op1, op2, result;
    logic [4:0]  sel;
    int          checks = 0;
    int          failures = 0;

`ifdef ALU_MDU_EN
    localparam bit MDU = 1'b1;
`else
    localparam bit MDU = 1'b0;
`endif

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic        sg;
        logic [31:0] r;
        logic        z;
        logic        n;
        logic        e;
    } vec_t;

    alu_mc #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .sel(sel), .is_signed(is_signed), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .Z(Z), .N(N), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no end of test, required finish before time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b,
                                input logic sg, input logic [31:0] r, input logic z,
                                input logic n, input logic e);
        vec_t v;
        v.sel = s; v.a = a; v.b = b; v.sg = sg; v.r = r; v.z = z; v.n = n; v.e = e;
        return v;
    endfunction

    function automatic int exp_lat(input logic [4:0] s);
        return (MDU && s >= 5'd10 && s <= 5'd17) ? 33 : 1;
    endfunction

    // Reference: plain RV32IM arithmetic on 64-bit integers
    function automatic void model(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b,
                                  input logic sg, output logic [31:0] r, output logic n,
                                  output logic e);
        longint     sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = 32'h0;
        e = 1'b0;
        p = 64'h0;
        case (s)
            5'd0: r = a + b;
            5'd1: r = a - b;
            5'd2: r = a & b;
            5'd3: r = a | b;
            5'd4: r = a ^ b;
            5'd5: r = a << b[4:0];
            5'd6: r = a >> b[4:0];
            5'd7: r = 32'($signed(a) >>> b[4:0]);
            5'd8: r = (sa < sb) ? 32'd1 : 32'd0;
            5'd9: r = (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_MDU_EN
            5'd10: begin p = {32'h0, a} * {32'h0, b}; r = p[31:0]; end
            5'd11: begin p = 64'(sa * sb); r = p[63:32]; end
            5'd12: begin p = 64'(sa * longint'({32'h0, b})); r = p[63:32]; end
            5'd13: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
            5'd14: r = (b == 0) ? 32'hFFFF_FFFF :
                       (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(sa / sb);
            5'd15: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd16: r = (b == 0) ? a :
                       (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sb);
            5'd17: r = (b == 0) ? a : a % b;
`endif
            default: e = 1'b1;
        endcase
        n = (s == 5'd1) ? (sg ? (sa < sb) : (a < b)) : r[31];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    task automatic idle(input int n);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Presents one op for a single accepting edge; returns at the following negedge
    task automatic send(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b,
                        input logic sg, input logic ordy);
        sel = s; op1 = a; op2 = b; is_signed = sg; out_ready = ordy; in_valid = 1'b1;
        #1;
        chk("send_in_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b,
                          input logic sg, output logic [31:0] r, output logic z,
                          output logic n, output logic e, output int lat);
        int k;
        sel = s; op1 = a; op2 = b; is_signed = sg; out_ready = 1'b1; in_valid = 1'b1;
        #1;
        k = 0;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("accept_wait", (k < 100) ? 32'd1 : 32'd0, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        r = result; z = Z; n = N; e = err;
    endtask

    initial begin
        vec_t        vt[$];
        logic [31:0] r, mr;
        logic        z, n, e, mn, me, sg;
        logic [31:0] a, b;
        logic [4:0]  s;
        int          lat, bad;

        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        sel = 5'd0; op1 = 32'h0; op2 = 32'h0; is_signed = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_z", Z, 0);
        chk("rst_n_flag", N, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);

        vt.push_back(mk(5'd0,  32'd5,          32'd7,  0, 32'd12,         0, 0, 0));
        vt.push_back(mk(5'd1,  32'hFFFF_FFFF,  32'd1,  1, 32'hFFFF_FFFE,  0, 1, 0));
        vt.push_back(mk(5'd1,  32'hFFFF_FFFF,  32'd1,  0, 32'hFFFF_FFFE,  0, 0, 0));
        vt.push_back(mk(5'd1,  32'd9,          32'd9,  0, 32'h0,          1, 0, 0));
        vt.push_back(mk(5'd0,  32'hFFFF_FFFF,  32'd1,  0, 32'h0,          1, 0, 0));
        vt.push_back(mk(5'd2,  32'hF0,         32'h3C, 0, 32'h30,         0, 0, 0));
        vt.push_back(mk(5'd3,  32'hF0,         32'h0F, 0, 32'hFF,         0, 0, 0));
        vt.push_back(mk(5'd4,  32'hF0,         32'hFF, 0, 32'h0F,         0, 0, 0));
        vt.push_back(mk(5'd5,  32'd1,          32'd31, 0, 32'h8000_0000,  0, 1, 0));
        vt.push_back(mk(5'd6,  32'h8000_0000,  32'd4,  0, 32'h0800_0000,  0, 0, 0));
        vt.push_back(mk(5'd7,  32'h8000_0000,  32'h24, 0, 32'hF800_0000,  0, 1, 0));
        vt.push_back(mk(5'd8,  32'hFFFF_FFFF,  32'd1,  0, 32'd1,          0, 0, 0));
        vt.push_back(mk(5'd9,  32'hFFFF_FFFF,  32'd1,  0, 32'd0,          1, 0, 0));
        vt.push_back(mk(5'd31, 32'd5,          32'd7,  0, 32'h0,          1, 0, 1));
        vt.push_back(mk(5'd18, 32'hFFFF_FFFF,  32'd7,  0, 32'h0,          1, 0, 1));
`ifdef ALU_MDU_EN
        vt.push_back(mk(5'd13, 32'h0001_0000,  32'h0001_0000, 0, 32'd1,   0, 0, 0));
        vt.push_back(mk(5'd10, 32'h0001_0000,  32'h0001_0000, 0, 32'd0,   1, 0, 0));
        vt.push_back(mk(5'd11, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0, 32'd0,   1, 0, 0));
        vt.push_back(mk(5'd12, 32'hFFFF_FFFF,  32'd2,  0, 32'hFFFF_FFFF,  0, 1, 0));
        vt.push_back(mk(5'd10, 32'd7,          32'd6,  0, 32'd42,         0, 0, 0));
        vt.push_back(mk(5'd14, 32'd7,          32'd0,  0, 32'hFFFF_FFFF,  0, 1, 0));
        vt.push_back(mk(5'd17, 32'd7,          32'd0,  0, 32'd7,          0, 0, 0));
        vt.push_back(mk(5'd14, 32'h8000_0000,  32'hFFFF_FFFF, 0, 32'h8000_0000, 0, 1, 0));
        vt.push_back(mk(5'd16, 32'h8000_0000,  32'hFFFF_FFFF, 0, 32'd0,   1, 0, 0));
        vt.push_back(mk(5'd14, 32'hFFFF_FFF9,  32'd2,  0, 32'hFFFF_FFFD,  0, 1, 0));
        vt.push_back(mk(5'd16, 32'hFFFF_FFF9,  32'd2,  0, 32'hFFFF_FFFF,  0, 1, 0));
        vt.push_back(mk(5'd15, 32'd100,        32'd7,  0, 32'd14,         0, 0, 0));
        vt.push_back(mk(5'd17, 32'd100,        32'd7,  0, 32'd2,          0, 0, 0));
        vt.push_back(mk(5'd14, 32'hFFFF_FFF9,  32'd0,  0, 32'hFFFF_FFFF,  0, 1, 0));
        vt.push_back(mk(5'd16, 32'hFFFF_FFF9,  32'd0,  0, 32'hFFFF_FFF9,  0, 1, 0));
`else
        vt.push_back(mk(5'd10, 32'd5,          32'd7,  0, 32'h0,          1, 0, 1));
        vt.push_back(mk(5'd14, 32'd7,          32'd0,  0, 32'h0,          1, 0, 1));
        vt.push_back(mk(5'd17, 32'd100,        32'd7,  0, 32'h0,          1, 0, 1));
`endif

        foreach (vt[i]) begin
            run_op(vt[i].sel, vt[i].a, vt[i].b, vt[i].sg, r, z, n, e, lat);
            chk($sformatf("vec%0d_result", i), r, vt[i].r);
            chk($sformatf("vec%0d_z", i), z, vt[i].z);
            chk($sformatf("vec%0d_n", i), n, vt[i].n);
            chk($sformatf("vec%0d_err", i), e, vt[i].e);
            chk($sformatf("vec%0d_latency", i), lat, exp_lat(vt[i].sel));
        end

        // Backpressure: result must hold while the consumer stalls
        idle(1);
        send(5'd4, 32'hF0, 32'hFF, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_result", result, 32'h0F);
            chk("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", in_ready, 1);
        @(negedge clk);
        chk("bp_release_drop", out_valid, 0);
        run_op(5'd0, 32'd1, 32'd1, 1'b0, r, z, n, e, lat);
        chk("bp_next_op", r, 32'd2);

        // Flush blocks acceptance and discards a pending result
        idle(1);
        sel = 5'd0; op1 = 32'd1; op2 = 32'd1; in_valid = 1'b1; flush = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_no_accept", out_valid, 0);
        send(5'd4, 32'h1, 32'h2, 1'b0, 1'b0);
        chk("flush_pre_valid", out_valid, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_drop_valid", out_valid, 0);

        // Async reset clears a held result
        idle(1);
        send(5'd0, 32'd3, 32'd4, 1'b0, 1'b0);
        chk("rst2_pre_result", result, 32'd7);
        rst_n = 1'b0;
        #1;
        chk("rst2_out_valid", out_valid, 0);
        chk("rst2_result", result, 0);
        chk("rst2_z", Z, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst2_in_ready", in_ready, 1);
        idle(1);

`ifdef ALU_MDU_EN
        // Multi-cycle latency with a stalled consumer
        send(5'd13, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0);
        bad = 0;
        for (int c = 1; c < 33; c++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("mul_busy_cycles", bad, 0);
        chk("mul_c33_valid", out_valid, 1);
        chk("mul_c33_in_ready", in_ready, 0);
        chk("mul_c33_result", result, 32'd1);
        repeat (3) @(negedge clk);
        chk("mul_hold_valid", out_valid, 1);
        chk("mul_hold_result", result, 32'd1);
        idle(1);

        // Flush at cycle 10 of a DIVU
        send(5'd15, 32'd100, 32'd7, 1'b0, 1'b1);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("div_flush_in_ready", in_ready, 0);
        @(negedge clk);
        flush = 1'b0;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("div_flush_no_result", bad, 0);
        chk("div_flush_idle", in_ready, 1);
        run_op(5'd0, 32'd2, 32'd3, 1'b0, r, z, n, e, lat);
        chk("div_flush_next", r, 32'd5);

        // Reset mid-multiply
        idle(1);
        send(5'd10, 32'd7, 32'd6, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mul_rst_valid", out_valid, 0);
        chk("mul_rst_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mul_rst_in_ready", in_ready, 1);
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("mul_rst_no_result", bad, 0);
`endif

        run_op(5'd31, 32'h1234, 32'h5678, 1'b0, r, z, n, e, lat);
        chk("undef_result", r, 0);
        chk("undef_z", z, 1);
        chk("undef_err", e, 1);

        for (int i = 0; i < 200; i++) begin
            s  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(18, 31)) : 5'($urandom_range(0, 17));
            a  = pick();
            b  = pick();
            sg = 1'($urandom_range(0, 1));
            run_op(s, a, b, sg, r, z, n, e, lat);
            model(s, a, b, sg, mr, mn, me);
            chk($sformatf("rnd%0d_sel%0d_result", i, s), r, mr);
            chk($sformatf("rnd%0d_sel%0d_z", i, s), z, (mr == 32'h0) ? 32'd1 : 32'd0);
            chk($sformatf("rnd%0d_sel%0d_n", i, s), n, mn);
            chk($sformatf("rnd%0d_sel%0d_err", i, s), e, me);
            chk($sformatf("rnd%0d_sel%0d_latency", i, s), lat, exp_lat(s));
        end

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
